// File: rtl/awmc_pkg.sv
// Shared types and helpers for the washing-machine cycle sequencer.
package awmc_pkg;

  localparam int unsigned MAX_STAGES = 16;
  localparam int unsigned IDX_W      = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } stage_sel_t;

  // Lowest enabled stage at or above index 'from'; found=0 when none remains.
  function automatic stage_sel_t next_enabled(input logic [MAX_STAGES-1:0] en,
                                              input logic [IDX_W-1:0]      from);
    stage_sel_t sel;
    sel = '0;
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (en[i] && (IDX_W'(i) >= from)) begin
        sel.found = 1'b1;
        sel.idx   = IDX_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/awmc_stage_timer.sv
// Per-stage down-counter: load with a duration (0 counts as 1), decrement when enabled.
module awmc_stage_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expire_c_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (load_val_i == '0) ? CNT_W'(1) : load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o      = cnt_q;
  assign expire_c_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/awmc_prog_seq.sv
// Programmable wash-cycle sequencer: walks enabled stages with per-stage durations,
// supporting pause, door interlock and abort.
module awmc_prog_seq
  import awmc_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = 5,
  parameter  int unsigned CNT_W      = 8,
  localparam int unsigned STG_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        door_open,
  input  logic                        abort,
  input  logic [NUM_STAGES-1:0]       stage_en,
  input  logic [NUM_STAGES*CNT_W-1:0] stage_len,
  output logic [STG_W-1:0]            stage_o,
  output logic [CNT_W-1:0]            remaining_o,
  output logic                        busy_o,
  output logic                        paused_o,
  output logic                        done_o
);

  localparam logic [STG_W-1:0] IDLE_CODE = '1;

  state_e                      state_q;
  logic [STG_W-1:0]            stage_q;
  logic [NUM_STAGES-1:0]       en_q;
  logic [NUM_STAGES*CNT_W-1:0] len_q;
  logic                        busy_q;
  logic                        paused_q;
  logic                        done_q;

  logic                        hold_c;
  logic                        start_go;
  stage_sel_t                  first_sel;
  stage_sel_t                  next_sel;
  logic                        tmr_clr;
  logic                        tmr_load;
  logic                        tmr_en;
  logic [CNT_W-1:0]            tmr_val;
  logic [CNT_W-1:0]            tmr_cnt;
  logic                        tmr_expire;

  function automatic logic [CNT_W-1:0] len_of(input logic [NUM_STAGES*CNT_W-1:0] lens,
                                              input logic [IDX_W-1:0]            idx);
    logic [CNT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (idx == IDX_W'(i)) v = lens[i*CNT_W +: CNT_W];
    end
    return v;
  endfunction

  // Stage lookup and timer control, shared by the FSM below.
  always_comb begin
    hold_c    = pause | door_open;
    first_sel = next_enabled(MAX_STAGES'(stage_en), '0);
    next_sel  = next_enabled(MAX_STAGES'(en_q), IDX_W'(stage_q) + IDX_W'(1));
    start_go  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = len_of(len_q, next_sel.idx);
    case (state_q)
      S_IDLE, S_DONE: begin
        start_go = start & ~hold_c;
        tmr_val  = len_of(stage_len, first_sel.idx);
        tmr_load = start_go & first_sel.found;
        tmr_clr  = start_go & ~first_sel.found;
      end
      S_RUN: begin
        tmr_en = ~hold_c;
        if (!hold_c && tmr_expire) begin
          tmr_load = next_sel.found;
          tmr_clr  = ~next_sel.found;
        end
      end
      default: ;
    endcase
    if (abort) tmr_clr = 1'b1;
  end

  awmc_stage_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .cnt_o      (tmr_cnt),
    .expire_c_o (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state_q  <= S_IDLE;
      stage_q  <= IDLE_CODE;
      en_q     <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_go) begin
            en_q  <= stage_en;
            len_q <= stage_len;
            if (first_sel.found) begin
              state_q <= S_RUN;
              stage_q <= STG_W'(first_sel.idx);
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (hold_c) begin
            state_q  <= S_PAUSED;
            paused_q <= 1'b1;
          end else if (tmr_expire) begin
            // Disabled stages are skipped within the same edge.
            if (next_sel.found) begin
              stage_q <= STG_W'(next_sel.idx);
            end else begin
              state_q <= S_DONE;
              stage_q <= IDLE_CODE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (!hold_c) begin
            state_q  <= S_RUN;
            paused_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stage_o     = stage_q;
  assign remaining_o = tmr_cnt;
  assign busy_o      = busy_q;
  assign paused_o    = paused_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_awmc_prog_seq.sv
// Scoreboard bench for awmc_prog_seq against a queue-of-stages reference model.
module tb_awmc_prog_seq;

  localparam int unsigned NS = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 3;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic             clk = 1'b0;
  logic             reset, start, pause, door_open, abort;
  logic [NS-1:0]    stage_en;
  logic [NS*CW-1:0] stage_len;
  logic [SW-1:0]    stage_o;
  logic [CW-1:0]    remaining_o;
  logic             busy_o, paused_o, done_o;

  typedef struct packed {
    logic [SW-1:0] stage;
    logic [CW-1:0] rem;
    logic          busy;
    logic          paused;
    logic          done;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Reference model: the program is a list of (stage, duration) visits.
  int m_mode = M_IDLE;
  int m_stg[$];
  int m_len[$];
  int m_rem  = 0;

  awmc_prog_seq #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .door_open   (door_open),
    .abort       (abort),
    .stage_en    (stage_en),
    .stage_len   (stage_len),
    .stage_o     (stage_o),
    .remaining_o (remaining_o),
    .busy_o      (busy_o),
    .paused_o    (paused_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    if (m_mode == M_RUN || m_mode == M_PAUSED) begin
      o.stage = SW'(m_stg[0]);
      o.rem   = CW'(m_rem);
      o.busy  = 1'b1;
    end else begin
      o.stage = 3'd7;
      o.rem   = '0;
      o.busy  = 1'b0;
    end
    o.paused = (m_mode == M_PAUSED);
    o.done   = (m_mode == M_DONE);
    return o;
  endfunction

  task automatic model_step();
    bit hold;
    int l;
    hold = pause || door_open;
    if (reset || abort) begin
      m_mode = M_IDLE;
      m_stg.delete();
      m_len.delete();
      m_rem = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (start && !hold) begin
            m_stg.delete();
            m_len.delete();
            for (int i = 0; i < NS; i++) begin
              if (stage_en[i]) begin
                l = int'(stage_len[i*CW +: CW]);
                m_stg.push_back(i);
                m_len.push_back((l == 0) ? 1 : l);
              end
            end
            if (m_stg.size() == 0) begin
              m_mode = M_DONE;
            end else begin
              m_mode = M_RUN;
              m_rem  = m_len[0];
            end
          end
        end
        M_RUN: begin
          if (hold) begin
            m_mode = M_PAUSED;
          end else if (m_rem == 1) begin
            void'(m_stg.pop_front());
            void'(m_len.pop_front());
            if (m_stg.size() == 0) begin
              m_mode = M_DONE;
              m_rem  = 0;
            end else begin
              m_rem = m_len[0];
            end
          end else begin
            m_rem = m_rem - 1;
          end
        end
        M_PAUSED: if (!hold) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of inputs, predict, and queue the expectation for after the edge.
  task automatic tick(input logic rst, input logic st, input logic pa,
                      input logic dr, input logic ab);
    obs_t pending;
    reset     = rst;
    start     = st;
    pause     = pa;
    door_open = dr;
    abort     = ab;
    model_step();
    pending = model_obs();
    @(posedge clk);
    #1;
    exp_q.push_back(pending);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_prog(input logic [NS-1:0] en, input logic [NS*CW-1:0] len);
    stage_en  = en;
    stage_len = len;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {stage_o, remaining_o, busy_o, paused_o, done_o};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs cyc %0d: got stage=%0d rem=%0d busy=%b paused=%b done=%b, want stage=%0d rem=%0d busy=%b paused=%b done=%b",
                 cyc, a.stage, a.rem, a.busy, a.paused, a.done,
                 e.stage, e.rem, e.busy, e.paused, e.done);
      end
    end
  end

  initial begin
    logic p_lvl, d_lvl;
    set_prog('0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // All stages, length 2 each, ends in DONE.
    set_prog(5'b11111, {5{8'd2}});
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_prog('0, '0);
    idle(12);

    // Sparse enable: stages 0,2,4 with lengths 2,3,4.
    set_prog(5'b10101, {8'd4, 8'd1, 8'd3, 8'd9, 8'd2});
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(11);

    // Pause three cycles while stage 1 shows remaining 2.
    set_prog(5'b11111, {5{8'd3}});
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(12);

    // Door interlock, abort while paused, then a full fresh run.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(17);

    // No stage enabled; then zero length plus start while running.
    set_prog('0, {5{8'd5}});
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    set_prog(5'b00110, {8'd1, 8'd1, 8'd3, 8'd0, 8'd1});
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Reset mid-stage 3; start with pause / door from IDLE and DONE.
    set_prog(5'b11111, {5{8'd2}});
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    set_prog('0, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Randomized traffic with program inputs changing every cycle.
    p_lvl = 1'b0;
    d_lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (p_lvl) p_lvl = ($urandom_range(0, 2) != 0);
      else       p_lvl = ($urandom_range(0, 19) == 0);
      if (d_lvl) d_lvl = ($urandom_range(0, 3) != 0);
      else       d_lvl = ($urandom_range(0, 59) == 0);
      stage_en = NS'($urandom);
      for (int i = 0; i < NS; i++) stage_len[i*CW +: CW] = CW'($urandom_range(0, 4));
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, p_lvl, d_lvl,
           $urandom_range(0, 79) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
